// File: rtl/add_pkg.sv
// Shared types and constants for the FP16 adder front end.
package add_pkg;

  localparam int EXP_W   = 5;
  localparam int FRAC_W  = 10;
  localparam int MANT_W  = FRAC_W + 1;
  localparam int EXP_MAX = 31;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp16_t;

  typedef struct packed {
    logic              sign;
    logic              if_sub;
    logic [EXP_W-1:0]  e_l;
    logic [MANT_W-1:0] m_l;
    logic [MANT_W-1:0] m_s;
    logic [EXP_W-1:0]  diff;
  } align_t;

  // Zero exponent covers both true zero and flushed subnormals.
  function automatic logic [MANT_W-1:0] unpack_mant(input fp16_t x);
    return (x.exp == '0) ? '0 : {1'b1, x.frac};
  endfunction

endpackage

// File: rtl/add_align_shifter.sv
// Logarithmic right shifter; any shift of W or more yields zero.
module add_align_shifter #(
  parameter int W    = add_pkg::MANT_W,
  parameter int SH_W = add_pkg::EXP_W
) (
  input  logic [W-1:0]    data_i,
  input  logic [SH_W-1:0] shamt_i,
  output logic [W-1:0]    data_o
);

  always_comb begin
    data_o = data_i;
    for (int k = 0; k < SH_W; k++) begin
      if (shamt_i[k]) data_o = data_o >> (1 << k);
    end
  end

endmodule

// File: rtl/add_aligner.sv
// Two-stage FP16 add front end: S1 orders operands by magnitude, S2 aligns and
// adds/subtracts the mantissas. Valid/ready on both sides.
module add_aligner
  import add_pkg::fp16_t, add_pkg::align_t, add_pkg::MANT_W, add_pkg::EXP_MAX, add_pkg::unpack_mant;
#(
  parameter int EXP_W  = add_pkg::EXP_W,
  parameter int FRAC_W = add_pkg::FRAC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       a,
  input  logic [15:0]       b,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              sign,
  output logic [EXP_W-1:0]  exponent,
  output logic [FRAC_W:0]   mantissa_add,
  output logic              if_sub,
  output logic              out_valid,
  input  logic              out_ready
);

  fp16_t             op_a, op_b;
  logic [MANT_W-1:0] m_a, m_b;
  logic              a_is_l;
  align_t            s1_d, s1_q;
  logic              s1_valid_q, s2_valid_q;
  logic              s1_adv, s2_adv;

  assign op_a   = a;
  assign op_b   = b;
  assign m_a    = unpack_mant(op_a);
  assign m_b    = unpack_mant(op_b);
  // Ties go to a; flushed subnormals compare as zero.
  assign a_is_l = {op_a.exp, m_a[FRAC_W-1:0]} >= {op_b.exp, m_b[FRAC_W-1:0]};

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    s1_d        = '0;
    s1_d.if_sub = op_a.sign ^ op_b.sign;
    if (a_is_l) begin
      s1_d.sign = op_a.sign;
      s1_d.e_l  = op_a.exp;
      s1_d.m_l  = m_a;
      s1_d.m_s  = m_b;
      s1_d.diff = op_a.exp - op_b.exp;
    end else begin
      s1_d.sign = op_b.sign;
      s1_d.e_l  = op_b.exp;
      s1_d.m_l  = m_b;
      s1_d.m_s  = m_a;
      s1_d.diff = op_b.exp - op_a.exp;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      // NOTE: datapath flops are reset too so outputs read as zero right after reset.
      s1_q       <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  logic [MANT_W-1:0] m_s_al;
  logic [MANT_W:0]   sum;
  logic [MANT_W-1:0] dif_m;
  logic [EXP_W-1:0]  e_inc;
  logic              sign_d, sign_q, if_sub_q;
  logic [EXP_W-1:0]  exponent_d, exponent_q;
  logic [FRAC_W:0]   mant_d, mant_q;

  add_align_shifter #(.W(MANT_W), .SH_W(EXP_W)) u_shifter (
    .data_i  (s1_q.m_s),
    .shamt_i (s1_q.diff),
    .data_o  (m_s_al)
  );

  always_comb begin
    sum        = {1'b0, s1_q.m_l} + {1'b0, m_s_al};
    dif_m      = s1_q.m_l - m_s_al;
    e_inc      = s1_q.e_l + EXP_W'(1);
    sign_d     = s1_q.sign;
    exponent_d = s1_q.e_l;
    mant_d     = sum[FRAC_W:0];
    if (!s1_q.if_sub) begin
      if (sum[MANT_W]) begin
        exponent_d = e_inc;
        // Carry into the maximum exponent becomes infinity downstream.
        mant_d     = (e_inc == EXP_W'(EXP_MAX)) ? {1'b1, {FRAC_W{1'b0}}} : sum[MANT_W:1];
      end
    end else if (dif_m == '0) begin
      sign_d     = 1'b0;
      exponent_d = '0;
      mant_d     = '0;
    end else begin
      mant_d     = dif_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      sign_q     <= 1'b0;
      exponent_q <= '0;
      mant_q     <= '0;
      if_sub_q   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        sign_q     <= sign_d;
        exponent_q <= exponent_d;
        mant_q     <= mant_d;
        if_sub_q   <= s1_q.if_sub;
      end
    end
  end

  assign out_valid    = s2_valid_q;
  assign sign         = sign_q;
  assign exponent     = exponent_q;
  assign mantissa_add = mant_q;
  assign if_sub       = if_sub_q;

endmodule

// File: tb/tb_add_aligner.sv
// Directed-vector bench for add_aligner: arithmetic cases, latency, backpressure and async reset.
module tb_add_aligner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] a = '0, b = '0;
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, sign, if_sub, out_valid;
  logic [4:0]  exponent;
  logic [10:0] mantissa_add;
  logic [31:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  add_aligner dut (
    .clk          (clk),
    .rst          (rst),
    .a            (a),
    .b            (b),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .sign         (sign),
    .exponent     (exponent),
    .mantissa_add (mantissa_add),
    .if_sub       (if_sub),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  always #5 clk = ~clk;

  assign obs = {14'd0, sign, exponent, mantissa_add, if_sub};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] res(input logic s, input logic [4:0] e,
                                      input logic [10:0] m, input logic is);
    return {14'd0, s, e, m, is};
  endfunction

  // One pair with out_ready high; result must appear exactly two edges after acceptance.
  task automatic run_one(input string tag, input logic [15:0] pa, input logic [15:0] pb,
                         input logic [31:0] want);
    @(negedge clk);
    a = pa; b = pb; in_valid = 1'b1; out_ready = 1'b1;
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_lat"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_vld"}, 32'(out_valid), 32'd1);
    check(tag, obs, want);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_q[3];
    int          got;
    logic        take;

    // Reset state
    #12;
    check("rst_ovalid", 32'(out_valid), 32'd0);
    check("rst_iready", 32'(in_ready), 32'd1);
    check("rst_data", obs, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Arithmetic vectors
    run_one("add_1p1",     16'h3C00, 16'h3C00, res(1'b0, 5'd16, 11'h400, 1'b0));
    run_one("add_carry",   16'h3E00, 16'h3C00, res(1'b0, 5'd16, 11'h500, 1'b0));
    run_one("add_nocarry", 16'h3C00, 16'h3400, res(1'b0, 5'd15, 11'h500, 1'b0));
    run_one("sub_swap",    16'hB800, 16'h3C00, res(1'b0, 5'd15, 11'h200, 1'b1));
    run_one("sub_neg_l",   16'hC000, 16'h3C00, res(1'b1, 5'd16, 11'h200, 1'b1));
    run_one("cancel",      16'h3C00, 16'hBC00, res(1'b0, 5'd0,  11'h000, 1'b1));
    run_one("cancel_neg",  16'hBC00, 16'h3C00, res(1'b0, 5'd0,  11'h000, 1'b1));
    run_one("big_shift",   16'h7800, 16'h0400, res(1'b0, 5'd30, 11'h400, 1'b0));
    run_one("overflow",    16'h7800, 16'h7800, res(1'b0, 5'd31, 11'h400, 1'b0));
    run_one("zeros",       16'h0000, 16'h0000, res(1'b0, 5'd0,  11'h000, 1'b0));
    run_one("subnorm",     16'h0200, 16'h3C00, res(1'b0, 5'd15, 11'h400, 1'b0));
    run_one("shift10",     16'h3C00, 16'h9401, res(1'b0, 5'd15, 11'h3FF, 1'b1));
    run_one("shift11",     16'h3C00, 16'h9001, res(1'b0, 5'd15, 11'h400, 1'b1));

    // Backpressure: three pairs, out_ready low for four edges
    exp_q[0] = res(1'b0, 5'd16, 11'h400, 1'b0);
    exp_q[1] = res(1'b0, 5'd16, 11'h500, 1'b0);
    exp_q[2] = res(1'b0, 5'd15, 11'h200, 1'b1);
    @(negedge clk);
    out_ready = 1'b0;
    a = 16'h3C00; b = 16'h3C00; in_valid = 1'b1;
    check("bp_rdy0", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("bp_rdy1", 32'(in_ready), 32'd1);
    a = 16'h3E00; b = 16'h3C00;
    @(negedge clk);
    check("bp_rdy2", 32'(in_ready), 32'd0);
    check("bp_s2_p0", obs, exp_q[0]);
    a = 16'hB800; b = 16'h3C00;
    @(negedge clk);
    check("bp_hold1", obs, exp_q[0]);
    check("bp_hold1_rdy", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("bp_hold2", obs, exp_q[0]);
    check("bp_hold2_vld", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 12 && got < 3; cyc++) begin
      if (out_valid) begin
        check($sformatf("bp_out%0d", got), obs, exp_q[got]);
        got++;
      end
      take = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (take) in_valid = 1'b0;
      @(negedge clk);
    end
    check("bp_count", 32'(got), 32'd3);
    @(negedge clk);
    check("bp_no_dup", 32'(out_valid), 32'd0);

    // Asynchronous reset with both stages full
    @(negedge clk);
    out_ready = 1'b0;
    a = 16'h3C00; b = 16'h3C00; in_valid = 1'b1;
    @(negedge clk);
    a = 16'h3E00; b = 16'h3C00;
    @(negedge clk);
    in_valid = 1'b0;
    check("mf_full_vld", 32'(out_valid), 32'd1);
    check("mf_full_rdy", 32'(in_ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("mf_rst_vld", 32'(out_valid), 32'd0);
    check("mf_rst_rdy", 32'(in_ready), 32'd1);
    check("mf_rst_data", obs, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    check("mf_post_vld", 32'(out_valid), 32'd0);
    run_one("post_rst", 16'h3E00, 16'h3C00, res(1'b0, 5'd16, 11'h500, 1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
